// File: rtl/ov7670_stream_gen.sv
// OV7670-style DVP stream generator: frame timing, byte-serial RGB565 output from a
// frame buffer, colour bars or a ramp.
module ov7670_stream_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  output logic [18:0] rd_addr,
  output logic        rd_en,
  input  logic [15:0] rd_data,
  output logic        vsync,
  output logic        hsync,
  output logic [7:0]  d,
  output logic        frame_done
);

  localparam int unsigned LineLen = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned BarW    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  localparam logic [10:0] HcLast     = 11'(LineLen - 1);
  localparam logic [10:0] HcPrefetch = 11'(LineLen - 2);
  localparam logic [10:0] HcActEnd   = 11'(2 * H_ACTIVE);
  localparam logic [10:0] HcFetchEnd = 11'(2 * H_ACTIVE - 2);
  localparam logic [9:0]  VsyncLast  = 10'(VSYNC_LINES - 1);
  localparam logic [9:0]  VbackLast  = 10'(V_BACK - 1);
  localparam logic [9:0]  VactLast   = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  VfrontLast = 10'(V_FRONT - 1);

  typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_e;

  state_e      state_q, state_d;
  logic [10:0] hc_q, hc_d;
  logic [9:0]  lc_q, lc_d, lc_last;
  logic [1:0]  mode_q, mode_d;
  logic [18:0] addr_q, addr_d;
  logic [15:0] pix_q, pix_d;

  logic        mem_mode, active_d, fetch_d;
  logic [9:0]  x, bar;
  logic [2:0]  bar_idx;
  logic [15:0] bar_pix, gen_pix, pix_sel;
  logic [7:0]  d_d;

  always_comb begin
    unique case (state_q)
      StVsync:  lc_last = VsyncLast;
      StVback:  lc_last = VbackLast;
      StActive: lc_last = VactLast;
      StVfront: lc_last = VfrontLast;
      default:  lc_last = '0;
    endcase
  end

  // Next position in the frame
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    lc_d    = lc_q;
    mode_d  = mode_q;
    if (state_q == StIdle) begin
      if (enable) begin
        state_d = StVsync;
        mode_d  = mode;
      end
    end else if (hc_q == HcLast) begin
      hc_d = '0;
      if (lc_q == lc_last) begin
        lc_d = '0;
        unique case (state_q)
          StVsync:  state_d = StVback;
          StVback:  state_d = StActive;
          StActive: state_d = StVfront;
          default: begin
            if (enable) begin
              state_d = StVsync;
              mode_d  = mode;
            end else begin
              state_d = StIdle;
            end
          end
        endcase
      end else begin
        lc_d = lc_q + 10'd1;
      end
    end else begin
      hc_d = hc_q + 11'd1;
    end
  end

  // Outputs are derived from the next position so they line up with the state registers
  always_comb begin
    x        = hc_d[10:1];
    bar      = x / 10'(BarW);
    bar_idx  = (bar > 10'd7) ? 3'd7 : bar[2:0];
    unique case (bar_idx)
      3'd0:    bar_pix = 16'hFFFF;
      3'd1:    bar_pix = 16'hFFE0;
      3'd2:    bar_pix = 16'h07FF;
      3'd3:    bar_pix = 16'h07E0;
      3'd4:    bar_pix = 16'hF81F;
      3'd5:    bar_pix = 16'hF800;
      3'd6:    bar_pix = 16'h001F;
      default: bar_pix = 16'h0000;
    endcase
    gen_pix  = (mode_d == 2'd1) ? bar_pix : 16'(x) + 16'(lc_d);
    mem_mode = (mode_d == 2'd0) || (mode_d == 2'd3);
    pix_sel  = mem_mode ? rd_data : gen_pix;
    active_d = (state_d == StActive) && (hc_d < HcActEnd);

    if (!active_d)      d_d = 8'h00;
    else if (!hc_d[0])  d_d = pix_sel[15:8];
    else                d_d = pix_q[7:0];
    pix_d = (active_d && !hc_d[0]) ? pix_sel : pix_q;

    // Read two cycles ahead of each high byte; pixel 0 is fetched from the preceding blank
    fetch_d = mem_mode &&
              (((state_d == StActive) && !hc_d[0] && (hc_d < HcFetchEnd)) ||
               ((hc_d == HcPrefetch) &&
                (((state_d == StActive) && (lc_d < VactLast)) ||
                 ((state_d == StVback) && (lc_d == VbackLast)))));

    addr_d = addr_q;
    if (state_d == StVsync && state_q != StVsync) addr_d = '0;
    else if (fetch_d)                             addr_d = addr_q + 19'd1;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      hc_q       <= '0;
      lc_q       <= '0;
      mode_q     <= '0;
      addr_q     <= '0;
      pix_q      <= '0;
      vsync      <= 1'b0;
      hsync      <= 1'b0;
      d          <= 8'h00;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      hc_q       <= hc_d;
      lc_q       <= lc_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      pix_q      <= pix_d;
      vsync      <= (state_d == StVsync);
      hsync      <= active_d;
      d          <= d_d;
      rd_en      <= fetch_d;
      rd_addr    <= fetch_d ? addr_q : '0;
      frame_done <= (state_d == StVfront) && (lc_d == VfrontLast) && (hc_d == HcLast);
    end
  end

endmodule

// File: doc/ov7670_stream_gen.md
OV7670_STREAM_GEN -- requirements
Module: ov7670_stream_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: pixels per active line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 144: blank byte-clocks per line, minimum 2.
REQ-004 SHALL have parameters VSYNC_LINES=3, V_BACK=17, V_FRONT=10: vsync, back-porch and front-porch lengths in lines, each at least 1.
REQ-005 SHALL have ports: pclk input 1 (byte clock, all logic on its rising edge).
REQ-006 rst input 1: reset, asynchronous, active-high.
REQ-007 enable input 1: run frames continuously while high.
REQ-008 mode input 2: pixel source, 0 = memory, 1 = colour bars, 2 = ramp, 3 = memory.
REQ-009 rd_addr output 19: frame-buffer pixel address.
REQ-010 rd_en output 1: frame-buffer read strobe.
REQ-011 rd_data input 16: RGB565 pixel, valid exactly 1 cycle after rd_en.
REQ-012 vsync output 1, hsync output 1, d output 8: DVP stream.
REQ-013 frame_done output 1: one-cycle pulse at frame end.

Function
REQ-014 SHALL register vsync, hsync, d, rd_addr, rd_en and frame_done; the DVP outputs SHALL change on the same pclk edge.
REQ-015 SHALL use FSM states IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
REQ-016 SHALL go from IDLE to VSYNC on the first cycle that enable is sampled high.
REQ-017 SHALL step VSYNC->VBACK->ACTIVE->VFRONT after VSYNC_LINES, V_BACK, V_ACTIVE and V_FRONT lines respectively.
REQ-018 SHALL go from VFRONT to VSYNC if enable=1 at frame end, else to IDLE.
REQ-019 Line length SHALL be L = 2*H_ACTIVE + H_BLANK pclk cycles, counted by an 11-bit horizontal counter hc, 0..L-1, wrapping at L-1.
REQ-020 The line counter SHALL be 10 bits and reset to 0 at each state transition.
REQ-021 vsync SHALL be 1 for every cycle of state VSYNC and 0 otherwise.
REQ-022 hsync SHALL be 1 only in ACTIVE, for hc < 2*H_ACTIVE, giving exactly one rising edge per active line.
REQ-023 In each ACTIVE slot, d SHALL carry pixel x = hc/2, high byte [15:8] on even hc and low byte [7:0] on odd hc.
REQ-024 d SHALL be 8'h00 whenever hsync is 0.
REQ-025 In memory mode, rd_en SHALL pulse exactly once per active pixel, with rd_addr = y*H_ACTIVE + x.
REQ-026 Each memory-mode read SHALL be issued early enough that the high byte appears with no gaps or stalls.
REQ-027 rd_addr SHALL start at 0 each frame and end at H_ACTIVE*V_ACTIVE-1.
REQ-028 rd_en SHALL be 0 in modes 1 and 2.
REQ-029 Colour bars (mode 1) SHALL use bar index x/(H_ACTIVE/8), saturated to 7.
REQ-030 Bar colours 0..7 SHALL be FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-031 Ramp (mode 2) SHALL output pixel = (x + y) modulo 2^16.
REQ-032 mode SHALL be sampled only on entry to VSYNC and held for the whole frame.
REQ-033 frame_done SHALL pulse for one cycle on the last cycle of VFRONT.
REQ-034 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame completes, then the FSM enters IDLE.
REQ-035 In IDLE, all outputs SHALL be 0.

Reset
REQ-036 While rst=1, asynchronously: state = IDLE, counters = 0, vsync = hsync = rd_en = frame_done = 0, d = 8'h00, rd_addr = 0.
REQ-037 rst asserted mid-line SHALL force outputs to 0 immediately, with no partial-line completion.
REQ-038 After rst is released, the first frame SHALL start with VSYNC.

Verification
REQ-039 Params H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, porches 1, mode 2, enable=1 -> L=10; vsync high 10 cycles; per frame, 2 hsync pulses of 8 cycles each; d line0 = 00,00,00,01,00,02,00,03; line1 = 00,01,00,02,00,03,00,04.
REQ-040 Same params, mode 0, memory returns addr*16'h0101 with 1-cycle latency -> 8 rd_en pulses, addrs 0..7; line1 bytes 04,04,05,05,06,06,07,07; next frame restarts at addr 0.
REQ-041 Mode 1 with H_ACTIVE=8 -> per line, pixels FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000, high byte first.
REQ-042 enable dropped during the second active line -> that frame completes, frame_done pulses once, then all outputs stay 0 and no further vsync occurs.
REQ-043 rst pulsed mid hsync -> vsync, hsync, d and rd_en are 0 in the same cycle; after release with enable=1, vsync rises 1 cycle later and rd_addr restarts at 0.
REQ-044 mode changed 1->2 mid-frame -> the current frame stays colour bars and the next frame is the ramp.
